// File: rtl/pattern_pkg.sv
// Shared types and constants for the multi-channel test-pattern generator.
package pattern_pkg;

    typedef enum logic [1:0] {
        ModeConst = 2'd0,
        ModeCount = 2'd1,
        ModeLfsr  = 2'd2,
        ModeTri   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_t;

    localparam logic [15:0] DefaultTaps = 16'hB400;

    // Channel index width; a single channel still gets a 1-bit index.
    function automatic int unsigned ch_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pattern_gen_if.sv
// Valid/ready sample stream produced by pattern_gen.
interface pattern_gen_if
    import pattern_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned N = 4
);
    localparam int unsigned CW = ch_width(N);

    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_ch;
    logic          out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_ch,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_ch,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/pattern_lane.sv
// One channel of pattern_gen: holds a sample value and triangle direction,
// loaded from a seed and advanced one step per transfer.
module pattern_lane
    import pattern_pkg::*;
#(
    parameter int unsigned     W    = 16,
    parameter logic [W-1:0]    TAPS = W'(DefaultTaps)
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         load,
    input  logic         advance,
    input  mode_t        mode,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] step,
    output logic [W-1:0] value
);

    logic [W-1:0] state_q, state_d;
    logic         dir_down_q, dir_down_d;
    logic [W:0]   sum_w;

    always_comb begin
        state_d    = state_q;
        dir_down_d = dir_down_q;
        // Extra bit catches overflow so the triangle turns instead of wrapping.
        sum_w      = {1'b0, state_q} + {1'b0, step};
        if (load) begin
            state_d    = (mode == ModeLfsr && seed == '0) ? W'(1) : seed;
            dir_down_d = 1'b0;
        end else if (advance) begin
            unique case (mode)
                ModeConst: state_d = state_q;
                ModeCount: state_d = state_q + step;
                ModeLfsr:  state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
                ModeTri: begin
                    if (!dir_down_q) begin
                        if (!sum_w[W]) begin
                            state_d = sum_w[W-1:0];
                        end else begin
                            state_d    = state_q - step;
                            dir_down_d = 1'b1;
                        end
                    end else if (state_q >= step) begin
                        state_d = state_q - step;
                    end else begin
                        state_d    = sum_w[W-1:0];
                        dir_down_d = 1'b0;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q    <= '0;
            dir_down_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_down_q <= dir_down_d;
        end
    end

    assign value = state_q;

endmodule

// File: rtl/pattern_gen.sv
// N-channel test-pattern generator (constant, counter, LFSR, triangle),
// channels time-multiplexed round-robin onto one valid/ready stream.
module pattern_gen
    import pattern_pkg::*;
#(
    parameter int unsigned  W    = 16,
    parameter int unsigned  N    = 4,
    parameter logic [W-1:0] TAPS = W'(DefaultTaps)
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         enable,
    input  mode_t        mode,
    input  logic [W-1:0] seed,
    input  logic [W-1:0] step,
    output logic         busy,
    pattern_gen_if.master stream
);

    localparam int unsigned CW = ch_width(N);

    state_t        state_q, state_d;
    logic [CW-1:0] ch_q, ch_d;
    mode_t         mode_q, lane_mode;
    logic [W-1:0]  step_q;
    logic          load, valid, xfer, at_last;
    logic [W-1:0]  lane_val [N];
    logic [W-1:0]  data;

    assign valid     = (state_q != StIdle);
    assign xfer      = valid && stream.out_ready;
    assign at_last   = (ch_q == CW'(N - 1));
    assign load      = (state_q == StIdle) && enable;
    assign lane_mode = load ? mode : mode_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StRun;
            StRun:   if (!enable) state_d = (xfer && at_last) ? StIdle : StDrain;
            StDrain: begin
                if (enable) begin
                    state_d = StRun;
                end else if (xfer && at_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ch_d = ch_q;
        if (load) begin
            ch_d = '0;
        end else if (xfer) begin
            ch_d = at_last ? '0 : ch_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= StIdle;
            ch_q    <= '0;
            mode_q  <= ModeConst;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            if (load) begin
                mode_q <= mode;
                step_q <= step;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        pattern_lane #(
            .W    (W),
            .TAPS (TAPS)
        ) u_lane (
            .clk     (clk),
            .n_reset (n_reset),
            .load    (load),
            .advance (xfer && (ch_q == CW'(i))),
            .mode    (lane_mode),
            .seed    (seed + W'(i)),
            .step    (step_q),
            .value   (lane_val[i])
        );
    end

    always_comb begin
        data = '0;
        for (int i = 0; i < N; i++) begin
            if (ch_q == CW'(i)) data = lane_val[i];
        end
    end

    assign stream.out_valid = valid;
    assign stream.out_data  = data;
    assign stream.out_ch    = ch_q;
    assign stream.out_last  = valid && at_last;
    assign busy             = valid;

endmodule

// File: tb/tb_pattern_gen.sv
// Directed, table-driven bench for pattern_gen across three parameter sets.
module tb_pattern_gen;
    import pattern_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        enable = 1'b0;
    logic        ready = 1'b1;
    mode_t       mode = ModeConst;
    logic [15:0] seed = '0;
    logic [15:0] step = '0;
    logic        busy_a, busy_b, busy_c;

    always #5 clk = ~clk;

    pattern_gen_if #(.W(16), .N(4)) ifa ();
    pattern_gen_if #(.W(16), .N(1)) ifb ();
    pattern_gen_if #(.W(4),  .N(1)) ifc ();

    assign ifa.out_ready = ready;
    assign ifb.out_ready = ready;
    assign ifc.out_ready = ready;

    pattern_gen #(.W(16), .N(4)) u_a (
        .clk(clk), .n_reset(n_reset), .enable(enable), .mode(mode),
        .seed(seed), .step(step), .busy(busy_a), .stream(ifa)
    );
    pattern_gen #(.W(16), .N(1)) u_b (
        .clk(clk), .n_reset(n_reset), .enable(enable), .mode(mode),
        .seed(seed), .step(step), .busy(busy_b), .stream(ifb)
    );
    pattern_gen #(.W(4), .N(1), .TAPS(4'h9)) u_c (
        .clk(clk), .n_reset(n_reset), .enable(enable), .mode(mode),
        .seed(seed[3:0]), .step(step[3:0]), .busy(busy_c), .stream(ifc)
    );

    // Observation mux over the three instances.
    int          sel = 0;
    logic        obs_valid, obs_last, obs_busy;
    logic [15:0] obs_data;
    logic [1:0]  obs_ch;

    always_comb begin
        case (sel)
            1: begin
                obs_valid = ifb.out_valid; obs_data = ifb.out_data;
                obs_ch = {1'b0, ifb.out_ch}; obs_last = ifb.out_last; obs_busy = busy_b;
            end
            2: begin
                obs_valid = ifc.out_valid; obs_data = {12'h000, ifc.out_data};
                obs_ch = {1'b0, ifc.out_ch}; obs_last = ifc.out_last; obs_busy = busy_c;
            end
            default: begin
                obs_valid = ifa.out_valid; obs_data = ifa.out_data;
                obs_ch = ifa.out_ch; obs_last = ifa.out_last; obs_busy = busy_a;
            end
        endcase
    end

    typedef struct {
        int          dut;
        mode_t       md;
        logic [15:0] sd;
        logic [15:0] st;
        int          first;
        int          count;
    } rec_t;

    rec_t        recs [8];
    logic [15:0] exp_tab [64];
    int          nrec = 0;
    int          nexp = 0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic add_rec(input int dut, input mode_t md, input logic [15:0] sd,
                           input logic [15:0] st);
        recs[nrec] = '{dut, md, sd, st, nexp, 0};
        nrec++;
    endtask

    task automatic push(input logic [15:0] v);
        exp_tab[nexp] = v;
        nexp++;
        recs[nrec-1].count++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        n_reset = 1'b0;
        enable  = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    task automatic run_rec(input int r);
        int         nch;
        logic [1:0] ech;
        sel = recs[r].dut;
        nch = (sel == 0) ? 4 : 1;
        do_reset();
        mode = recs[r].md; seed = recs[r].sd; step = recs[r].st;
        ready = 1'b1; enable = 1'b1;
        @(negedge clk);
        // Inputs changed after the load must have no effect.
        mode = (recs[r].md == ModeConst) ? ModeCount : ModeConst;
        seed = 16'hDEAD; step = 16'h0777;
        for (int k = 0; k < recs[r].count; k++) begin
            ech = 2'(k % nch);
            chk($sformatf("rec%0d data k=%0d", r, k), {16'h0, obs_data},
                {16'h0, exp_tab[recs[r].first + k]});
            chk($sformatf("rec%0d valid/ch/last k=%0d", r, k),
                {28'h0, obs_valid, obs_ch, obs_last},
                {28'h0, 1'b1, ech, (k % nch) == (nch - 1)});
            if (k == recs[r].count - 1) enable = 1'b0;
            @(negedge clk);
        end
        chk($sformatf("rec%0d idle after last", r), {30'h0, obs_valid, obs_busy}, 32'h0);
    endtask

    task automatic chk_a(input string name, input logic [15:0] d, input logic [1:0] c,
                         input logic v, input logic l);
        chk({name, " data"}, {16'h0, obs_data}, {16'h0, d});
        chk({name, " ctl"}, {28'h0, obs_valid, obs_ch, obs_last}, {28'h0, v, c, l});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Directed sample tables.
        add_rec(0, ModeCount, 16'h0010, 16'h0002);
        push(16'h0010); push(16'h0011); push(16'h0012); push(16'h0013);
        push(16'h0012); push(16'h0013); push(16'h0014); push(16'h0015);
        add_rec(1, ModeCount, 16'hFFFF, 16'h0001);
        push(16'hFFFF); push(16'h0000); push(16'h0001);
        add_rec(1, ModeLfsr, 16'h0000, 16'h0005);
        push(16'h0001); push(16'hB400); push(16'h5A00);
        add_rec(2, ModeTri, 16'h000D, 16'h0002);
        push(16'd13); push(16'd15); push(16'd13); push(16'd11); push(16'd9); push(16'd7);
        push(16'd5);  push(16'd3);  push(16'd1);  push(16'd3);  push(16'd5);
        add_rec(0, ModeConst, 16'h1234, 16'h0005);
        push(16'h1234); push(16'h1235); push(16'h1236); push(16'h1237);
        push(16'h1234); push(16'h1235); push(16'h1236); push(16'h1237);
        add_rec(0, ModeLfsr, 16'hFFFD, 16'h0000);
        push(16'hFFFD); push(16'hFFFE); push(16'hFFFF); push(16'h0001);
        push(16'hCBFE); push(16'h7FFF); push(16'hCBFF); push(16'hB400);
        add_rec(0, ModeTri, 16'hFFFE, 16'h0001);
        push(16'hFFFE); push(16'hFFFF); push(16'h0000); push(16'h0001);
        push(16'hFFFF); push(16'hFFFE); push(16'h0001); push(16'h0002);

        // Reset wins over a pending enable.
        sel = 0;
        n_reset = 1'b0; enable = 1'b1; mode = ModeCount; seed = 16'h4321; step = 16'h0001;
        @(negedge clk);
        @(negedge clk);
        chk_a("reset A", 16'h0000, 2'd0, 1'b0, 1'b0);
        chk("reset A busy", {31'h0, busy_a}, 32'h0);
        chk("reset B/C valid", {30'h0, ifb.out_valid, ifc.out_valid}, 32'h0);
        enable = 1'b0;
        n_reset = 1'b1;

        for (int r = 0; r < nrec; r++) run_rec(r);

        // Back-pressure: ready toggles every 3 cycles, counter mode.
        begin
            int k;
            sel = 0;
            do_reset();
            mode = ModeCount; seed = 16'h0100; step = 16'h0001;
            ready = 1'b0; enable = 1'b1;
            @(negedge clk);
            mode = ModeLfsr; seed = 16'h0BAD; step = 16'h0033;
            k = 0;
            for (int cyc = 0; cyc < 25; cyc++) begin
                chk_a($sformatf("stall cyc=%0d", cyc), 16'h0100 + 16'(k % 4) + 16'(k / 4),
                      2'(k % 4), 1'b1, (k % 4) == 3);
                ready = ((cyc / 3) % 2) == 1;
                if (ready) k++;
                @(negedge clk);
            end
            ready = 1'b1;
        end

        // Enable dropped at ch1: remaining channels drain, then idle.
        do_reset();
        mode = ModeCount; seed = 16'h0020; step = 16'h0001; enable = 1'b1;
        @(negedge clk); chk_a("drain s0", 16'h0020, 2'd0, 1'b1, 1'b0);
        @(negedge clk); chk_a("drain s1", 16'h0021, 2'd1, 1'b1, 1'b0);
        enable = 1'b0;
        @(negedge clk); chk_a("drain s2", 16'h0022, 2'd2, 1'b1, 1'b0);
        chk("drain busy", {31'h0, busy_a}, 32'h1);
        @(negedge clk); chk_a("drain s3", 16'h0023, 2'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("drain idle", {30'h0, obs_valid, obs_busy}, 32'h0);

        // Re-enable during drain resumes without reloading.
        do_reset();
        mode = ModeCount; seed = 16'h0040; step = 16'h0001; enable = 1'b1;
        @(negedge clk); chk_a("resume s0", 16'h0040, 2'd0, 1'b1, 1'b0);
        @(negedge clk); chk_a("resume s1", 16'h0041, 2'd1, 1'b1, 1'b0);
        enable = 1'b0;
        @(negedge clk); chk_a("resume s2", 16'h0042, 2'd2, 1'b1, 1'b0);
        enable = 1'b1; seed = 16'h7000;
        @(negedge clk); chk_a("resume s3", 16'h0043, 2'd3, 1'b1, 1'b1);
        @(negedge clk); chk_a("resume s4", 16'h0041, 2'd0, 1'b1, 1'b0);
        @(negedge clk); chk_a("resume s5", 16'h0042, 2'd1, 1'b1, 1'b0);

        // Reset mid-run abandons the sample; next cycle is idle, then a fresh load.
        n_reset = 1'b0;
        @(negedge clk);
        chk_a("midreset", 16'h0000, 2'd0, 1'b0, 1'b0);
        chk("midreset busy", {31'h0, busy_a}, 32'h0);
        n_reset = 1'b1; seed = 16'h0055;
        @(negedge clk); chk_a("after reset", 16'h0055, 2'd0, 1'b1, 1'b0);
        enable = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
